// File: rtl/pwm_adc_seq.sv
// pwm_adc_seq -- ultrasound burst sequencer (PWM excitation + ADC sampling).
//
// On an accepted start the block drives a PWM burst, idles for a blanking
// interval, strobes the ADC at a programmable rate and presents each captured
// sample on a one-deep valid/ready output register.
//
// Optional feature: define PWM_ADC_SEQ_COMPL_EN to add the complementary
// drive output pwm_out_n and its dead-time parameter DEAD.
//
// Ports
//   clk, reset_n       : clock, asynchronous active-low reset
//   pll_locked         : PLL lock (asynchronous, synchronized internally)
//   start              : one-cycle sequence request
//   pwm_period/pwm_high: PWM period and high time in clocks
//   burst_len          : number of PWM periods in the burst
//   blank_cycles       : idle clocks between burst and sampling
//   sample_div         : clocks between ADC strobes (0 behaves as 1)
//   num_samples        : number of ADC strobes
//   adc_data           : ADC word, valid while adc_strobe is high
//   pwm_out, pwm_out_n : excitation drive (pwm_out_n only with the macro)
//   adc_strobe         : ADC sample strobe
//   smp_data/smp_valid/smp_ready : captured sample stream
//   busy, done, err, overrun     : status (err and overrun are sticky)
module pwm_adc_seq #(
  parameter int ADC_W = 12,
  parameter int CNT_W = 16
`ifdef PWM_ADC_SEQ_COMPL_EN
  ,
  parameter int DEAD  = 2
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             start,
  input  logic [CNT_W-1:0] pwm_period,
  input  logic [CNT_W-1:0] pwm_high,
  input  logic [7:0]       burst_len,
  input  logic [CNT_W-1:0] blank_cycles,
  input  logic [7:0]       sample_div,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [ADC_W-1:0] adc_data,
  output logic             pwm_out,
`ifdef PWM_ADC_SEQ_COMPL_EN
  output logic             pwm_out_n,
`endif
  output logic             adc_strobe,
  output logic [ADC_W-1:0] smp_data,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, BURST, BLANK, SAMPLE, DONE} state_t;

  logic             r_lock_meta, r_lock_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;   // cycle-in-period / blank count / clocks since strobe
  logic [7:0]       r_per;   // PWM period index within the burst
  logic [CNT_W-1:0] r_smp;   // strobes issued so far
  logic [CNT_W-1:0] r_period, r_high, r_blank, r_num;
  logic [7:0]       r_burst, r_div;
  logic             r_pwm, r_strobe, r_busy, r_done, r_err, r_ovr;
  logic [ADC_W-1:0] r_smp_data;
  logic             r_smp_valid;

  state_t           w_nxt_state, w_acc_state, w_post_burst, w_post_blank;
  logic             w_enter, w_accept, w_cfg_err, w_abort;
  logic             w_per_end, w_burst_end, w_blank_end;
  logic [CNT_W-1:0] w_c_next, w_div_last;
  logic [7:0]       w_div_eff;

`ifdef PWM_ADC_SEQ_COMPL_EN
  logic r_pwm_n;

  // Complementary drive is high only in the low part of the period, shrunk by
  // DEAD clocks on both sides. One extra bit keeps high+DEAD from wrapping.
  function automatic logic f_compl(input logic [CNT_W-1:0] c,
                                   input logic [CNT_W-1:0] h,
                                   input logic [CNT_W-1:0] p);
    logic [CNT_W:0] c_w;
    c_w = {1'b0, c};
    f_compl = (c_w >= ({1'b0, h} + (CNT_W+1)'(DEAD))) &&
              ((c_w + (CNT_W+1)'(DEAD)) < {1'b0, p});
  endfunction
`endif

  // Phase-end detection on the latched configuration
  assign w_per_end   = (r_cnt == r_period - CNT_W'(1));
  assign w_burst_end = w_per_end && (r_per == r_burst - 8'd1);
  assign w_blank_end = (r_cnt == r_blank - CNT_W'(1));
  assign w_div_eff   = (r_div == 8'd0) ? 8'd1 : r_div;
  assign w_div_last  = CNT_W'(w_div_eff - 8'd1);
  assign w_c_next    = w_per_end ? '0 : r_cnt + CNT_W'(1);

  // Empty phases are skipped, so the entry state may chain several steps
  assign w_post_blank = (r_num != '0) ? SAMPLE : DONE;
  assign w_post_burst = (r_blank != '0) ? BLANK : w_post_blank;
  assign w_acc_state  = (burst_len != 8'd0)   ? BURST  :
                        (blank_cycles != '0)  ? BLANK  :
                        (num_samples != '0)   ? SAMPLE : DONE;

  always_comb begin
    w_nxt_state = r_state;
    w_enter     = 1'b0;
    w_accept    = 1'b0;
    w_cfg_err   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && r_lock_s) begin
          if (pwm_period < CNT_W'(2)) begin
            w_cfg_err = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_enter     = 1'b1;
            w_nxt_state = w_acc_state;
          end
        end
      end
      BURST: begin
        if (w_burst_end) begin
          w_enter     = 1'b1;
          w_nxt_state = w_post_burst;
        end
      end
      BLANK: begin
        if (w_blank_end) begin
          w_enter     = 1'b1;
          w_nxt_state = w_post_blank;
        end
      end
      SAMPLE: begin
        // Leave right after the cycle that carried the last strobe
        if (r_smp == r_num) begin
          w_enter     = 1'b1;
          w_nxt_state = DONE;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
    if ((r_state != IDLE) && !r_lock_s) begin
      w_abort     = 1'b1;
      w_enter     = 1'b0;
      w_nxt_state = IDLE;
    end
  end

  // Lock synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Sequencer state, counters and registered drive/status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_per    <= '0;
      r_smp    <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_blank  <= '0;
      r_num    <= '0;
      r_burst  <= '0;
      r_div    <= '0;
      r_pwm    <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef PWM_ADC_SEQ_COMPL_EN
      r_pwm_n  <= 1'b0;
`endif
    end else begin
      r_state  <= w_nxt_state;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (w_accept) begin
        r_period <= pwm_period;
        r_high   <= pwm_high;
        r_burst  <= burst_len;
        r_blank  <= blank_cycles;
        r_div    <= sample_div;
        r_num    <= num_samples;
        r_err    <= 1'b0;
      end
      if (w_cfg_err) r_err <= 1'b1;
      if (w_abort) begin
        r_pwm  <= 1'b0;
        r_busy <= 1'b0;
        r_err  <= 1'b1;
`ifdef PWM_ADC_SEQ_COMPL_EN
        r_pwm_n <= 1'b0;
`endif
      end else if (w_enter) begin
        // BURST is only ever entered from IDLE, so the live inputs apply here
        r_cnt    <= '0;
        r_per    <= '0;
        r_smp    <= CNT_W'(1);
        r_pwm    <= (w_nxt_state == BURST) && (pwm_high != '0);
        r_strobe <= (w_nxt_state == SAMPLE);
        r_done   <= (w_nxt_state == DONE);
        r_busy   <= (w_nxt_state == BURST) || (w_nxt_state == BLANK) ||
                    (w_nxt_state == SAMPLE);
`ifdef PWM_ADC_SEQ_COMPL_EN
        r_pwm_n  <= (w_nxt_state == BURST) && f_compl('0, pwm_high, pwm_period);
`endif
      end else begin
        case (r_state)
          BURST: begin
            r_cnt <= w_c_next;
            r_pwm <= (w_c_next < r_high);
            if (w_per_end) r_per <= r_per + 8'd1;
`ifdef PWM_ADC_SEQ_COMPL_EN
            r_pwm_n <= f_compl(w_c_next, r_high, r_period);
`endif
          end
          BLANK: r_cnt <= r_cnt + CNT_W'(1);
          SAMPLE: begin
            if (r_cnt == w_div_last) begin
              r_strobe <= 1'b1;
              r_cnt    <= '0;
              r_smp    <= r_smp + CNT_W'(1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // One-deep sample output register; a strobe that finds it full and not
  // being drained drops the new word and flags overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_smp_data  <= '0;
      r_smp_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_accept) r_ovr <= 1'b0;
      if (r_strobe) begin
        if (!r_smp_valid || smp_ready) begin
          r_smp_data  <= adc_data;
          r_smp_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_smp_valid && smp_ready) begin
        r_smp_valid <= 1'b0;
      end
    end
  end

  assign pwm_out    = r_pwm;
  assign adc_strobe = r_strobe;
  assign smp_data   = r_smp_data;
  assign smp_valid  = r_smp_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign overrun    = r_ovr;
`ifdef PWM_ADC_SEQ_COMPL_EN
  assign pwm_out_n  = r_pwm_n;
`endif

endmodule

// File: tb/tb_pwm_adc_seq.sv
// Self-checking bench for pwm_adc_seq: directed and randomized sequences
// compared cycle by cycle against an arithmetic timeline model and a
// one-deep stream model.
module tb_pwm_adc_seq;
  localparam int ADC_W = 12;
  localparam int CNT_W = 16;
`ifdef PWM_ADC_SEQ_COMPL_EN
  localparam int DEAD = 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pll_locked = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] pwm_period = '0, pwm_high = '0, blank_cycles = '0, num_samples = '0;
  logic [7:0]       burst_len = '0, sample_div = '0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             smp_ready = 1'b0;
  logic             pwm_out, adc_strobe, smp_valid, busy, done, err, overrun;
  logic [ADC_W-1:0] smp_data;
`ifdef PWM_ADC_SEQ_COMPL_EN
  logic             pwm_out_n;
`endif

  pwm_adc_seq #(.ADC_W(ADC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .start(start),
    .pwm_period(pwm_period), .pwm_high(pwm_high), .burst_len(burst_len),
    .blank_cycles(blank_cycles), .sample_div(sample_div), .num_samples(num_samples),
    .adc_data(adc_data), .pwm_out(pwm_out),
`ifdef PWM_ADC_SEQ_COMPL_EN
    .pwm_out_n(pwm_out_n),
`endif
    .adc_strobe(adc_strobe), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .busy(busy), .done(done), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Stream model: the word the output register should hold, and overrun
  logic             m_valid = 1'b0;
  logic [ADC_W-1:0] m_data = '0;
  logic             m_ovr = 1'b0;
  int               rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Observe one cycle at its falling edge, then drive ready/adc_data for the
  // rest of the cycle and advance the stream model accordingly.
  task automatic step(input logic e_pwm, input logic e_strb, input logic e_busy,
                      input logic e_done);
    logic rdy;
    logic [ADC_W-1:0] adc;
    @(negedge clk);
    chk("pwm_out", pwm_out, e_pwm);
    chk("adc_strobe", adc_strobe, e_strb);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("smp_valid", smp_valid, m_valid);
    if (m_valid) chk("smp_data", smp_data, m_data);
    rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    adc = ADC_W'($urandom_range(0, 4095));
    smp_ready = rdy;
    adc_data  = adc;
    if (e_strb) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = adc;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One full sequence; abort_k > 0 drops pll_locked during cycle abort_k.
  task automatic run(input int p, input int h, input int b, input int bl,
                     input int d, input int n, input int mode, input int abort_k);
    int bp, div_e, s0, done_k, last_k, c;
    logic ab, e_pwm, e_strb, e_busy, e_done;
    bp     = b * p;
    div_e  = (d == 0) ? 1 : d;
    s0     = 1 + bp + bl;
    done_k = (n == 0) ? s0 : s0 + (n - 1) * div_e + 1;
    last_k = (abort_k > 0) ? abort_k + 5 : done_k + 1;
    rdy_mode = mode;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pwm_period   = CNT_W'(p);
    pwm_high     = CNT_W'(h);
    burst_len    = 8'(b);
    blank_cycles = CNT_W'(bl);
    sample_div   = 8'(d);
    num_samples  = CNT_W'(n);
    start        = 1'b1;
    m_ovr        = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      ab     = (abort_k > 0) && (k >= abort_k + 3);
      c      = (k - 1) % p;
      e_pwm  = !ab && (k <= bp) && (c < h);
      e_strb = !ab && (n > 0) && (k >= s0) && ((k - s0) % div_e == 0) &&
               ((k - s0) / div_e < n);
      e_busy = !ab && (k < done_k);
      e_done = !ab && (k == done_k);
      step(e_pwm, e_strb, e_busy, e_done);
`ifdef PWM_ADC_SEQ_COMPL_EN
      chk("pwm_out_n", pwm_out_n, !ab && (k <= bp) && (c >= h + DEAD) && (c + DEAD < p));
`endif
      if (k == 1) begin
        start        = 1'b0;
        pwm_period   = CNT_W'($urandom_range(0, 3));
        pwm_high     = CNT_W'($urandom_range(0, 3));
        burst_len    = 8'($urandom_range(0, 9));
        blank_cycles = CNT_W'($urandom_range(0, 9));
      end
      if (k == abort_k) pll_locked = 1'b0;
    end
    chk("err", err, abort_k > 0);
    chk("overrun", overrun, m_ovr);
    if (abort_k > 0) begin
      pll_locked = 1'b1;
      idle(3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset: every output low while reset_n is held
    repeat (3) @(negedge clk);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_adc_strobe", adc_strobe, 0);
    chk("rst_smp_data", smp_data, 0);
    chk("rst_smp_valid", smp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_overrun", overrun, 0);
`ifdef PWM_ADC_SEQ_COMPL_EN
    chk("rst_pwm_out_n", pwm_out_n, 0);
`endif
    reset_n = 1'b1;
    idle(3);

    // Reference burst: strobes at t+46/48/50, done at t+51
    run(10, 3, 4, 5, 2, 3, 0, 0);

    // start while unlocked is ignored
    pll_locked = 1'b0;
    idle(3);
    pwm_period = 16'd10; pwm_high = 16'd3; burst_len = 8'd2;
    blank_cycles = 16'd1; sample_div = 8'd1; num_samples = 16'd1;
    start = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    idle(4);
    chk("unlocked_err", err, 0);
    pll_locked = 1'b1;
    idle(3);

    // start with a period below 2 sets err and stays idle
    pwm_period = 16'd1;
    start = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    chk("period1_err", err, 1);
    idle(3);
    chk("period1_err_sticky", err, 1);

    // Back-pressure: first sample held, later strobes dropped
    run(4, 2, 1, 2, 1, 3, 1, 0);
    rdy_mode = 0;
    idle(3);

    // Lock lost mid-burst
    run(10, 3, 4, 5, 2, 3, 0, 12);

    // All phases empty: done on the first cycle, no pwm or strobe
    run(5, 2, 0, 0, 0, 0, 2, 0);

    // High time beyond the period keeps pwm_out high through the burst
    run(10, 12, 2, 1, 0, 2, 2, 0);

    // Randomized sequences with random back-pressure
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(2, 12), $urandom_range(0, 14), $urandom_range(0, 3),
          $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 5), 2, 0);
    end
    rdy_mode = 0;
    idle(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_adc_seq.md
# pwm_adc_seq

Burst sequencer in the ultrasound PWM/ADC clock domain, clocked by the 100 MHz PWM_ADC PLL output and gated by its `locked` signal. On `start` it emits a PWM excitation burst to the transducer driver and waits out a blanking interval. It then strobes the ADC at a programmable rate and streams the captured samples out over a valid/ready interface toward the FIFO/HPS bridge.

## Interface
- `ADC_W`, 12, ADC sample width.
- `CNT_W`, 16, width of period, blanking and sample-count fields.
- `DEAD`, 2, complementary-output dead time in clocks; used only with `PWM_ADC_SEQ_COMPL_EN`.
- `clk` in 1: 100 MHz PLL output clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`; passes through a 2-flop synchronizer.
- `start` in 1: single-cycle request to run one sequence.
- `pwm_period` in CNT_W: PWM period in clocks.
- `pwm_high` in CNT_W: high time in clocks.
- `burst_len` in 8: number of PWM periods.
- `blank_cycles` in CNT_W: idle clocks between burst and sampling.
- `sample_div` in 8: clocks between ADC strobes; 0 is treated as 1.
- `num_samples` in CNT_W: number of ADC strobes.
- `adc_data` in ADC_W: ADC output, valid on the cycle `adc_strobe` is high.
- `pwm_out` out 1: excitation drive.
- `pwm_out_n` out 1: complementary drive; present only with the macro defined.
- `adc_strobe` out 1: sample strobe.
- `smp_data` out ADC_W, `smp_valid` out 1, `smp_ready` in 1: sample stream.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (sticky), `overrun` out 1 (sticky).

## Operation
- FSM states: IDLE, BURST, BLANK, SAMPLE, DONE.
- IDLE: `start` is accepted only when `lock_s`=1 and `pwm_period` ≥ 2.
  - `start` with `pwm_period` < 2: sets `err` and the FSM stays in IDLE.
  - `start` while `lock_s`=0: ignored.
  - On accept, all config inputs are latched; later input changes do not affect the running sequence.
  - Accept clears `err` and `overrun`.
- BURST: cycle counter `c` runs 0..period−1 and wraps; `pwm_out = (c < pwm_high)`.
  - `pwm_high` ≥ period gives constant high.
  - Ends after `burst_len` periods; `burst_len`=0 skips to BLANK.
- BLANK: `pwm_out`=0 for `blank_cycles` clocks; 0 skips straight to SAMPLE.
- SAMPLE: `adc_strobe` pulses on the first SAMPLE cycle, then every `sample_div` clocks, `num_samples` times in total.
  - `num_samples`=0 goes straight to DONE.
- Capture on each strobe edge:
  - If the output register is empty, or `smp_ready` is high this cycle, load `smp_data` ← `adc_data` and set `smp_valid`.
  - Otherwise drop the sample, keep the held sample, and set `overrun`.
- Stream rule: `smp_valid` clears on `smp_valid & smp_ready` unless reloaded in the same cycle. `smp_data` is stable while `smp_valid & !smp_ready`.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE. The held sample remains valid until it is consumed.
- Lock loss: `lock_s` falling in any non-IDLE state aborts the sequence.
  - Next cycle: IDLE, `pwm_out`=0, `adc_strobe`=0, `err`=1, no `done`.
  - A pending sample stays valid.
- `start` in a non-IDLE state is ignored.
- Counters are CNT_W wide and unsigned, with no saturation.

## Timing
- Reset (`reset_n`=0, asynchronous): FSM=IDLE, synchronizer=0, and every output is 0:
  - `pwm_out`, `pwm_out_n`, `adc_strobe`, `smp_data`, `smp_valid`, `busy`, `done`, `err`, `overrun`.
- All outputs are registered.
- `start` accepted at cycle t:
  - `busy`=1 from t+1.
  - First `pwm_out` high at t+1 (if `burst_len`>0 and `pwm_high`>0).
- BURST occupies exactly `burst_len`·`pwm_period` cycles, and BLANK exactly `blank_cycles` cycles.
- First strobe: t+1+`burst_len`·`pwm_period`+`blank_cycles`.
- `smp_valid` rises the cycle after its strobe.
- `done` pulses 1 cycle after the last strobe (or after the last BLANK cycle when `num_samples`=0).
- `pll_locked` to `lock_s` latency: 2 cycles.

## Configuration
- `PWM_ADC_SEQ_COMPL_EN`:
  - Defined: `pwm_out_n` exists. During BURST, `pwm_out_n = (c ≥ pwm_high+DEAD) && (c < pwm_period−DEAD)`; it is 0 in all other states and on abort.
  - Undefined: port and logic are absent; everything else is unchanged.

## Test plan
- Reset with `pll_locked`=1, then `start` with period=10, high=3, burst=4, blank=5, div=2, samples=3, `smp_ready`=1 -> 4 pulses of 3 high/7 low; strobes at t+46, t+48, t+50; 3 samples equal to the driven `adc_data`; `done` at t+51.
- `start` while `pll_locked`=0 -> no activity, `busy`=0; `start` with period=1 -> `err`=1, FSM stays in IDLE.
- `smp_ready`=0, samples=3, div=1 -> first sample held; `overrun`=1; `smp_data` equals the first sample until ready.
- Drop `pll_locked` mid-BURST -> 2 cycles later (synchronizer) plus 1 cycle: `pwm_out`=0, `busy`=0, `err`=1, no `done`.
- burst=0, blank=0, samples=0 -> `done` at t+1; `pwm_out` and `adc_strobe` never assert; high=12 with period=10 -> `pwm_out` constant high across the burst.
- With `PWM_ADC_SEQ_COMPL_EN`, DEAD=2, period=10, high=3 -> `pwm_out_n` high only for c=5..7; never high together with `pwm_out`.
